// File: rtl/dtpu_pkg.sv
// Shared types and constants for the MAC result path.
// Precision codes, lane boundary masks and accumulator FSM states.
package dtpu_pkg;

  localparam logic [3:0] PREC_8  = 4'h1;
  localparam logic [3:0] PREC_16 = 4'h3;
  localparam logic [3:0] PREC_32 = 4'h7;
  localparam logic [3:0] PREC_64 = 4'hF;

  // Bit i set: byte slice i is the top byte of its lane.
  localparam logic [7:0] LANE_BOUNDARY_8  = 8'hFF;
  localparam logic [7:0] LANE_BOUNDARY_16 = 8'hAA;
  localparam logic [7:0] LANE_BOUNDARY_32 = 8'h88;
  localparam logic [7:0] LANE_BOUNDARY_64 = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN
  } acc_state_t;

  function automatic logic prec_legal(
    input logic [3:0] p
  );
    case (p)
      PREC_8, PREC_16,
      PREC_32, PREC_64: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] lane_boundary(
    input logic [3:0] p
  );
    case (p)
      PREC_8:  return LANE_BOUNDARY_8;
      PREC_16: return LANE_BOUNDARY_16;
      PREC_32: return LANE_BOUNDARY_32;
      default: return LANE_BOUNDARY_64;
    endcase
  endfunction

  // Low byte-index bits that stay inside one lane.
  function automatic logic [2:0] lane_span(
    input logic [3:0] p
  );
    case (p)
      PREC_8:  return 3'd0;
      PREC_16: return 3'd1;
      PREC_32: return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/simd_sat_add.sv
// Packed SIMD saturating adder: eight byte slices with carry kill
// at lane boundaries and per-lane clamp to max/min.
module simd_sat_add
  import dtpu_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [3:0]  prec,
  output logic [63:0] sum,
  output logic        sat
);

  logic [7:0]  bnd;
  logic [2:0]  span;
  logic [63:0] raw;
  logic [7:0]  ovf;
  logic [8:0]  s9;
  logic        carry;
  logic [2:0]  top;
  logic        neg;

  assign bnd  = lane_boundary(prec);
  assign span = lane_span(prec);

  always_comb begin
    raw   = '0;
    ovf   = '0;
    s9    = '0;
    carry = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s9 = {1'b0, a[8*i +: 8]}
         + {1'b0, b[8*i +: 8]}
         + {8'd0, carry};
      raw[8*i +: 8] = s9[7:0];
      carry = s9[8] & ~bnd[i];
      ovf[i] = bnd[i]
             & (a[8*i+7] == b[8*i+7])
             & (s9[7] != a[8*i+7]);
    end
  end

  assign sat = |ovf;

  // Each byte follows the overflow of its lane's top slice.
  always_comb begin
    sum = raw;
    top = '0;
    neg = 1'b0;
    for (int i = 0; i < 8; i++) begin
      top = 3'(i) | span;
      neg = a[{top, 3'b111}];
      if (ovf[top]) begin
        if (3'(i) == top)
          sum[8*i +: 8] = neg ? 8'h80 : 8'h7F;
        else
          sum[8*i +: 8] = neg ? 8'h00 : 8'hFF;
      end
    end
  end

endmodule

// File: rtl/mac_result_accumulator.sv
// Burst accumulator behind the last MAC row: sums acc_len beats
// per SIMD lane with saturation and holds the result for write-back.
module mac_result_accumulator
  import dtpu_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] res_mac_in,
  input  logic [3:0]            select_precision,
  input  logic [LEN_WIDTH-1:0]  acc_len,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] res_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  sat_flag,
  output logic                  prec_err
);

  acc_state_t            state;
  acc_state_t            state_nx;
  logic [DATA_WIDTH-1:0] acc;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [3:0]            prec_q;
  logic                  sat_q;
  logic                  perr_q;
  logic                  beat;
  logic                  start;
  logic                  step;
  logic                  last;
  logic                  one_beat;
  logic                  out_xfer;
  logic [63:0]           add_sum;
  logic                  add_sat;

  assign beat     = enable && in_ready;
  assign out_xfer = res_valid && res_ready;
  // In DRAIN a beat implies res_ready, so it coincides with the output transfer.
  assign start    = beat && (state != ACCUM);
  assign step     = beat && (state == ACCUM);
  assign last     = remaining == LEN_WIDTH'(1);
  assign one_beat = acc_len == LEN_WIDTH'(1);

  simd_sat_add u_add (
    .a    (acc),
    .b    (res_mac_in),
    .prec (prec_q),
    .sum  (add_sum),
    .sat  (add_sat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:
          if (beat)
            state_nx = one_beat ? DRAIN : ACCUM;
        ACCUM:
          if (beat && last)
            state_nx = DRAIN;
        DRAIN:
          if (out_xfer)
            state_nx = !beat ? IDLE
                     : one_beat ? DRAIN : ACCUM;
        default:
          state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    res_valid = (state == DRAIN);
    in_ready  = (state == DRAIN) ? res_ready : 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      remaining <= '0;
      prec_q    <= PREC_64;
      sat_q     <= 1'b0;
      perr_q    <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      remaining <= '0;
      prec_q    <= PREC_64;
      sat_q     <= 1'b0;
      perr_q    <= 1'b0;
    end else if (start) begin
      acc       <= res_mac_in;
      remaining <= acc_len - LEN_WIDTH'(1);
      prec_q    <= prec_legal(select_precision)
                   ? select_precision : PREC_64;
      sat_q     <= 1'b0;
      perr_q    <= !prec_legal(select_precision);
    end else if (step) begin
      acc       <= add_sum;
      remaining <= remaining - LEN_WIDTH'(1);
      sat_q     <= sat_q | add_sat;
    end
  end

  assign res_out  = acc;
  assign sat_flag = sat_q;
  assign prec_err = perr_q;

endmodule

// File: tb/tb_mac_result_accumulator.sv
// Scoreboard bench for mac_result_accumulator: bursts are modelled
// lane by lane with wide signed arithmetic and compared on output.
module tb_mac_result_accumulator;

  typedef struct {
    logic [63:0] res;
    logic        sat;
    logic        perr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        in_ready;
  logic [63:0] res_mac_in = '0;
  logic [3:0]  select_precision = 4'h1;
  logic [7:0]  acc_len = 8'd1;
  logic        clear = 1'b0;
  logic [63:0] res_out;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic        sat_flag;
  logic        prec_err;

  int checks = 0;
  int failures = 0;

  exp_t        sb[$];
  logic [63:0] m_acc;
  logic        m_sat;
  logic        m_perr;
  logic [3:0]  m_prec;
  int          m_left = 0;

  always #5 clk = ~clk;

  mac_result_accumulator dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .in_ready         (in_ready),
    .res_mac_in       (res_mac_in),
    .select_precision (select_precision),
    .acc_len          (acc_len),
    .clear            (clear),
    .res_out          (res_out),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .sat_flag         (sat_flag),
    .prec_err         (prec_err)
  );

  // Returns {saturated, sum}.
  function automatic logic [64:0] model_add(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [3:0]  p
  );
    int w;
    logic [63:0] r;
    logic s;
    logic signed [63:0] ta, tb;
    logic signed [64:0] x, y, z, mx, mn;
    logic [63:0] mask;
    w = (p == 4'h1) ? 8 : (p == 4'h3) ? 16 : (p == 4'h7) ? 32 : 64;
    r = '0;
    s = 1'b0;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    for (int lo = 0; lo < 64; lo += w) begin
      ta = signed'(a >> lo) <<< (64 - w);
      tb = signed'(b >> lo) <<< (64 - w);
      x = ta >>> (64 - w);
      y = tb >>> (64 - w);
      z = x + y;
      mx = (65'sd1 <<< (w - 1)) - 65'sd1;
      mn = -(65'sd1 <<< (w - 1));
      if (z > mx) begin z = mx; s = 1'b1; end
      else if (z < mn) begin z = mn; s = 1'b1; end
      r = r | ((z[63:0] & mask) << lo);
    end
    return {s, r};
  endfunction

  // Drives one beat (DUT must be ready) and updates the scoreboard model.
  task automatic send(input logic [63:0] d, input logic [3:0] p, input logic [7:0] l);
    logic [64:0] m;
    if (m_left == 0) begin
      m_perr = !(p == 4'h1 || p == 4'h3 || p == 4'h7 || p == 4'hF);
      m_prec = m_perr ? 4'hF : p;
      m_acc  = d;
      m_sat  = 1'b0;
      m_left = (l == 8'd0) ? 256 : int'(l);
    end else begin
      m = model_add(m_acc, d, m_prec);
      m_acc = m[63:0];
      m_sat = m_sat | m[64];
    end
    m_left--;
    if (m_left == 0) sb.push_back('{m_acc, m_sat, m_perr});
    enable = 1'b1;
    res_mac_in = d;
    select_precision = p;
    acc_len = l;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks += 5;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
    if (res_out !== 64'h0) begin failures++; $display("FAIL reset_res_out got=%h want=0", res_out); end
    if (sat_flag !== 1'b0) begin failures++; $display("FAIL reset_sat got=%b want=0", sat_flag); end
    if (prec_err !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b want=0", prec_err); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic8();
    exp_t e;
    send({8{8'h01}}, 4'h1, 8'd2);
    send({8{8'h02}}, 4'h1, 8'd2);
    enable = 1'b0;
    checks++;
    if (res_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL basic8_latency res_valid=%b want=1", res_valid);
    end else begin
      e = sb.pop_front();
      checks += 2;
      if (res_out !== e.res) begin failures++; $display("FAIL basic8_res got=%h want=%h", res_out, e.res); end
      if (sat_flag !== e.sat) begin failures++; $display("FAIL basic8_sat got=%b want=%b", sat_flag, e.sat); end
    end
    @(negedge clk);
  endtask

  task automatic test_sat8();
    logic [63:0] pa[2] = '{{8{8'h7F}}, {8{8'h80}}};
    logic [63:0] pb[2] = '{{8{8'h01}}, {8{8'hFF}}};
    exp_t e;
    int n;
    for (int k = 0; k < 2; k++) begin
      send(pa[k], 4'h1, 8'd2);
      send(pb[k], 4'h1, 8'd2);
      enable = 1'b0;
      n = 0;
      while (!res_valid && n < 8) begin @(negedge clk); n++; end
      checks++;
      if (!res_valid || sb.size() == 0) begin
        failures++; $display("FAIL sat8_timeout res_valid=%b want=1", res_valid);
      end else begin
        e = sb.pop_front();
        checks += 2;
        if (res_out !== e.res) begin failures++; $display("FAIL sat8_res[%0d] got=%h want=%h", k, res_out, e.res); end
        if (sat_flag !== e.sat) begin failures++; $display("FAIL sat8_flag[%0d] got=%b want=%b", k, sat_flag, e.sat); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_prec_sweep();
    logic [3:0]  pr[4] = '{4'h1, 4'h3, 4'h7, 4'hF};
    logic [63:0] want[4] = '{{4{16'h94FC}}, {4{16'h95FC}},
                             {2{32'h95FD95FC}}, 64'h95FD95FD95FD95FC};
    exp_t e;
    int n;
    for (int k = 0; k < 4; k++) begin
      send({4{16'hCAFE}}, pr[k], 8'd2);
      send({4{16'hCAFE}}, pr[k], 8'd2);
      enable = 1'b0;
      n = 0;
      while (!res_valid && n < 8) begin @(negedge clk); n++; end
      checks++;
      if (!res_valid || sb.size() == 0) begin
        failures++; $display("FAIL sweep_timeout prec=%h res_valid=%b", pr[k], res_valid);
      end else begin
        e = sb.pop_front();
        checks += 3;
        if (res_out !== e.res) begin failures++; $display("FAIL sweep_res prec=%h got=%h want=%h", pr[k], res_out, e.res); end
        if (res_out !== want[k]) begin failures++; $display("FAIL sweep_const prec=%h got=%h want=%h", pr[k], res_out, want[k]); end
        if (sat_flag !== 1'b0) begin failures++; $display("FAIL sweep_sat prec=%h got=%b want=0", pr[k], sat_flag); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    res_ready = 1'b0;
    send(64'h0001_0002_7FFF_8000, 4'h3, 8'd2);
    send(64'h0003_0004_0001_FFFF, 4'h3, 8'd2);
    enable = 1'b0;
    e = sb.pop_front();
    for (int c = 0; c < 3; c++) begin
      checks += 4;
      if (res_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b want=1", c, res_valid); end
      if (res_out !== e.res) begin failures++; $display("FAIL bp_res[%0d] got=%h want=%h", c, res_out, e.res); end
      if (sat_flag !== e.sat) begin failures++; $display("FAIL bp_sat[%0d] got=%b want=%b", c, sat_flag, e.sat); end
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b want=0", c, in_ready); end
      @(negedge clk);
    end
    res_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b want=1", in_ready); end
    send(64'hA5A5_0000_1111_2222, 4'h1, 8'd1);
    enable = 1'b0;
    checks++;
    if (res_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL b2b_valid got=%b want=1", res_valid);
    end else begin
      e = sb.pop_front();
      checks += 2;
      if (res_out !== e.res) begin failures++; $display("FAIL b2b_res got=%h want=%h", res_out, e.res); end
      if (prec_err !== 1'b0) begin failures++; $display("FAIL b2b_perr got=%b want=0", prec_err); end
    end
    @(negedge clk);
  endtask

  task automatic test_clear();
    exp_t e;
    int n;
    for (int k = 1; k <= 3; k++) send(64'(k * 64'h0101), 4'h1, 8'd5);
    enable = 1'b1;
    res_mac_in = 64'hFFFF;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    enable = 1'b0;
    m_left = 0;
    for (int c = 0; c < 3; c++) begin
      checks += 3;
      if (res_valid !== 1'b0) begin failures++; $display("FAIL clear_valid[%0d] got=%b want=0", c, res_valid); end
      if (res_out !== 64'h0) begin failures++; $display("FAIL clear_res[%0d] got=%h want=0", c, res_out); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL clear_in_ready[%0d] got=%b want=1", c, in_ready); end
      @(negedge clk);
    end
    send(64'h0123_4567_89AB_CDEF, 4'h1, 8'd1);
    enable = 1'b0;
    n = 0;
    while (!res_valid && n < 8) begin @(negedge clk); n++; end
    checks++;
    if (!res_valid || sb.size() == 0) begin
      failures++; $display("FAIL clear_next_timeout res_valid=%b", res_valid);
    end else begin
      e = sb.pop_front();
      checks++;
      if (res_out !== e.res) begin failures++; $display("FAIL clear_next_res got=%h want=%h", res_out, e.res); end
    end
    @(negedge clk);
  endtask

  task automatic test_illegal_prec();
    logic [3:0] p0[3] = '{4'h5, 4'h5, 4'h1};
    logic [3:0] p1[3] = '{4'h5, 4'h1, 4'hF};
    logic [7:0] ln[3] = '{8'd1, 8'd2, 8'd2};
    exp_t e;
    int n;
    for (int k = 0; k < 3; k++) begin
      send((k == 0) ? 64'h1234 : 64'hFF, p0[k], ln[k]);
      if (ln[k] == 8'd2) send(64'h01, p1[k], 8'd2);
      enable = 1'b0;
      n = 0;
      while (!res_valid && n < 8) begin @(negedge clk); n++; end
      checks++;
      if (!res_valid || sb.size() == 0) begin
        failures++; $display("FAIL illegal_timeout[%0d] res_valid=%b", k, res_valid);
      end else begin
        e = sb.pop_front();
        checks += 3;
        if (res_out !== e.res) begin failures++; $display("FAIL illegal_res[%0d] got=%h want=%h", k, res_out, e.res); end
        if (prec_err !== e.perr) begin failures++; $display("FAIL illegal_perr[%0d] got=%b want=%b", k, prec_err, e.perr); end
        if (sat_flag !== e.sat) begin failures++; $display("FAIL illegal_sat[%0d] got=%b want=%b", k, sat_flag, e.sat); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_len_wrap();
    exp_t e;
    int n;
    for (int k = 0; k < 255; k++) send(64'd1, 4'hF, 8'd0);
    checks++;
    if (res_valid !== 1'b0) begin failures++; $display("FAIL wrap_early got=%b want=0", res_valid); end
    send(64'd1, 4'hF, 8'd0);
    enable = 1'b0;
    n = 0;
    while (!res_valid && n < 8) begin @(negedge clk); n++; end
    checks++;
    if (!res_valid || sb.size() == 0) begin
      failures++; $display("FAIL wrap_timeout res_valid=%b", res_valid);
    end else begin
      e = sb.pop_front();
      checks++;
      if (res_out !== e.res) begin failures++; $display("FAIL wrap_res got=%h want=%h", res_out, e.res); end
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    res_ready = 1'b0;
    send(64'hDEAD_BEEF_0000_0001, 4'h1, 8'd1);
    enable = 1'b0;
    checks++;
    if (res_valid !== 1'b1) begin failures++; $display("FAIL areset_pre got=%b want=1", res_valid); end
    #2 reset = 1'b1;
    #1;
    checks += 3;
    if (res_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b want=0", res_valid); end
    if (res_out !== 64'h0) begin failures++; $display("FAIL areset_res got=%h want=0", res_out); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL areset_in_ready got=%b want=1", in_ready); end
    sb.delete();
    m_left = 0;
    @(negedge clk);
    reset = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic8();
    test_sat8();
    test_prec_sweep();
    test_back_to_back();
    test_clear();
    test_illegal_prec();
    test_len_wrap();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d want=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_result_accumulator.md
# mac_result_accumulator

Downstream stage of the MAC chain. Consumes the 64-bit packed result `res_mac_n64` that leaves the last MAC row and accumulates a programmable number of beats per SIMD lane, at the lane precision selected by `select_precision`. Each lane uses saturating two's-complement addition. The finished sum is presented on a valid/ready output register toward the result write-back path.

## Interface
Parameters:
- `DATA_WIDTH`, 64: packed result width; fixed at 64 for this revision.
- `LEN_WIDTH`, 8: width of the beat counter and of `acc_len`.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `enable` in 1: input beat valid, driven from the MAC chain.
- `in_ready` out 1: block can accept a beat.
- `res_mac_in` in 64: packed MAC result beat.
- `select_precision` in 4: lane precision.
  - 4'h1: 8×8-bit lanes.
  - 4'h3: 4×16-bit lanes.
  - 4'h7: 2×32-bit lanes.
  - 4'hF: 1×64-bit lane.
- `acc_len` in 8: beats per burst; 0 means 256.
- `clear` in 1: synchronous abort of the current burst.
- `res_out` out 64: accumulated packed result.
- `res_valid` out 1: `res_out` is valid.
- `res_ready` in 1: consumer accepts `res_out`.
- `sat_flag` out 1: at least one lane saturated during the burst; qualified by `res_valid`.
- `prec_err` out 1: the burst started with an illegal `select_precision`; qualified by `res_valid`.

## Operation
- **Transfer rules.**
  - Input transfer happens when `enable && in_ready`.
  - Output transfer happens when `res_valid && res_ready`.
- **FSM states: IDLE, ACCUM, DRAIN.**
- **IDLE.**
  - `in_ready`=1.
  - The first accepted beat loads `acc`=`res_mac_in` with no add.
  - That beat latches precision and `acc_len`, and sets `remaining`=len−1.
  - If len==1, go to DRAIN; otherwise go to ACCUM.
- **ACCUM.**
  - `in_ready`=1.
  - Each accepted beat does `acc` ← `sat_add(acc, beat, prec)` and decrements `remaining`.
  - The beat that arrives with `remaining`==1 is the last beat; go to DRAIN after it.
  - Cycles without `enable` hold all state.
- **DRAIN.**
  - `res_valid`=1 and `in_ready`=`res_ready`.
  - On output transfer with no input beat, go to IDLE.
  - On output transfer with a simultaneous input beat, that beat starts a new burst exactly as in IDLE. This gives zero-bubble back-to-back bursts.
- **Latched controls.** `select_precision` and `acc_len` are sampled only at the first beat of a burst. Changes during a burst are ignored.
- **Illegal precision** (any value other than 1/3/7/F): the burst is treated as 64-bit and `prec_err` is set for the burst.
- **Saturating add, per lane.**
  - Overflow occurs when both operands have the same sign and the sum's sign differs.
  - On positive overflow the lane saturates to 0x7F…F; on negative overflow it saturates to 0x80…0.
  - Lanes are independent; no carry crosses a lane boundary.
- **`sat_flag`** is sticky over the burst and is cleared when a new burst starts.
- **`clear`.**
  - Has priority over all other inputs.
  - Next state is IDLE with `acc`, `remaining`, `res_valid`, `sat_flag` and `prec_err` all set to 0.
  - A beat presented in the same cycle is dropped.
- **Reset** (asynchronous, at any time, including mid-burst or during DRAIN): all outputs take their reset values immediately and the FSM goes to IDLE.

## Timing
- **Reset values:**
  - `in_ready`=1
  - `res_valid`=0
  - `res_out`=64'h0
  - `sat_flag`=0
  - `prec_err`=0
- **Latency.** `res_valid` rises on the clock edge that accepts the last beat, i.e. it is visible in the cycle after the last-beat transfer.
- **Throughput.** One beat per cycle. Back-to-back bursts run with no idle cycle while `res_ready`=1.
- **Output stability.** While `res_valid`=1 and `res_ready`=0, `res_out`, `sat_flag` and `prec_err` hold stable and `in_ready`=0.
- **`in_ready` is combinational from `res_ready` only in DRAIN.** There is no other combinational input-to-output path.
- **`acc_len`=0** runs a 256-beat burst; the counter is 8 bits and wraps.

## Structure
- **Shared package `dtpu_pkg`:**
  - precision encodings `PREC_8`=4'h1, `PREC_16`=4'h3, `PREC_32`=4'h7, `PREC_64`=4'hF;
  - state enum `acc_state_t` {IDLE, ACCUM, DRAIN};
  - `LANE_BOUNDARY` masks per precision.
- **Sub-module `simd_sat_add`.**
  - Combinational.
  - Inputs: `a`[63:0], `b`[63:0], `prec`[3:0].
  - Outputs: `sum`[63:0], `sat`.
  - Implemented as eight 8-bit slices with carry kill at lane boundaries, plus per-lane saturation muxes.
- **Top level** holds the FSM, `remaining` counter, `acc` register and latched precision/length.

## Test plan
- **8-bit basic:** prec=1, len=2, beats 64'h0101…01 then 64'h0202…02 → `res_out`=64'h0303…03 one cycle after the 2nd beat, `sat_flag`=0.
- **8-bit saturation:** prec=1, len=2, beats 64'h7F7F…7F then 64'h0101…01 → `res_out`=64'h7F7F…7F, `sat_flag`=1. Repeat with 64'h8080…80 + 64'hFFFF…FF → 64'h8080…80, `sat_flag`=1.
- **Precision sweep:** beats {4{16'hCAFE}} twice with len=2 at prec=1/3/7/F:
  - prec=1 → {4{16'h94FC}}
  - prec=3 → {4{16'h95FC}}
  - prec=7 → {2{32'h95FD95FC}}
  - prec=F → 64'h95FD95FD95FD95FC
  - `sat_flag`=0 in every case.
- **Backpressure and back-to-back:**
  - Hold `res_ready`=0 for 3 cycles in DRAIN → `res_out` stable, `in_ready`=0.
  - Then `res_ready`=1 together with `enable`=1 → the new burst starts in the same cycle with no bubble.
- **Clear and reset:**
  - `clear` pulse after beat 3 of 5 → IDLE, `res_valid` never asserts, and the following len=1 burst returns its single beat unchanged.
  - Asynchronous `reset` asserted mid-cycle during DRAIN → `res_valid`=0 and `res_out`=0 immediately, before the next edge.
- **Illegal precision:** prec=4'h5, len=1, beat 64'h1234 → `res_out`=64'h1234, `prec_err`=1. A changed `select_precision` mid-burst has no effect on lane splitting.
